bcd_stopwatch_ctrl: RTL and testbench
=====================================

// Module: bcd_stopwatch_ctrl
// PURPOSE
// - Sequencing controller for a chain of mod-10 (0..9) decade digit counters.
// - Generates the count-enable tick from a clock prescaler.
// - Runs a start/stop/clear/lap FSM.
// - Ripples carries digit-to-digit; all digits update on the same clock edge.
// - Drives the BCD display path (7-seg mux downstream).
// PARAMETERS
// - NUM_DIGITS  4      number of cascaded decade digits (1..8)
// - PRESCALE    50000  Clk cycles per count tick (>=2)
// - PRESCALE_W  16     prescaler width; 2**PRESCALE_W >= PRESCALE
// PORTS
// - Clk      in   1             single clock, rising edge
// - RST      in   1             asynchronous reset, active-high
// - START    in   1             start/resume request, level sampled each cycle
// - STOP     in   1             pause request
// - CLEAR    in   1             zero all digits, return to IDLE
// - LAP      in   1             toggle display freeze while counting
// - COUNT    out  4*NUM_DIGITS  live BCD value; digit 0 = bits [3:0]
// - DISP     out  4*NUM_DIGITS  display value: COUNT, or the frozen lap value in HOLD
// - RUNNING  out  1             1 in RUN or HOLD
// - OVF      out  1             sticky; set when all digits roll over from 9..9 to 0..0
// - STATE    out  2             IDLE=00, RUN=01, PAUSE=10, HOLD=11
// BEHAVIOUR
// - Reset (RST=1, asynchronous):
//   - STATE=IDLE; COUNT=0, DISP=0, prescaler=0, OVF=0, RUNNING=0.
// - Command priority within a cycle: CLEAR > STOP > START > LAP. Lower-priority commands are ignored that cycle.
// - FSM transitions:
//   - Any state, CLEAR: -> IDLE; COUNT, prescaler, DISP and OVF all zeroed next edge.
//   - IDLE or PAUSE, START: -> RUN.
//   - RUN or HOLD, STOP: -> PAUSE; DISP tracks COUNT again.
//   - RUN, LAP: -> HOLD; DISP captures COUNT as it is that edge, before any increment.
//   - HOLD, LAP: -> RUN.
//   - All other cases hold state.
//   - START in RUN/HOLD, STOP in IDLE/PAUSE, LAP in IDLE/PAUSE: no effect.
// - Prescaler:
//   - Advances only in RUN/HOLD. Counts 0..PRESCALE-1, then wraps to 0.
//   - tick=1 for one cycle when the prescaler equals PRESCALE-1 in RUN/HOLD.
//   - Retains its value in PAUSE, so resuming loses no fraction of a tick. Zeroed only by CLEAR/reset.
//   - A tick coinciding with STOP or CLEAR is discarded.
// - Digit chain:
//   - Digit k increments on tick when digits 0..k-1 all equal 9.
//   - 9 -> 0 wrap. Any illegal value above 9 loads 0 on its next enable.
//   - COUNT reflects a tick on the edge after the cycle where the prescaler is at PRESCALE-1 (1-cycle latency).
//   - Full rollover (all digits 9 on tick): all digits -> 0, OVF<=1. OVF holds until CLEAR/reset.
// - DISP: equals COUNT combinationally in IDLE/RUN/PAUSE; a register value in HOLD.
// - RUNNING and STATE are registered and decode the FSM state directly.
// - Reset mid-count: immediate asynchronous zeroing. No partial carry survives.
// STRUCTURE
// - Package stopwatch_pkg:
//   - FSM state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_HOLD (2-bit).
//   - Constant BCD_MAX=4'd9.
// - Sub-module bcd_digit, one instance per digit via generate:
//   - Ports: Clk, RST, EN, CLR, Q[3:0], TC.
//   - TC = (Q==9), combinational. Chain enable = tick & TC of all lower digits.
// - Top level holds the FSM, prescaler, lap register and OVF flag.
// TESTING (NUM_DIGITS=2, PRESCALE=3 unless noted)
// - Reset then START held 1 cycle:
//   - STATE=01 next edge.
//   - First COUNT=0x01 three cycles after entering RUN; 0x10 after 30 cycles.
// - Count to 0x99, one more tick -> COUNT=0x00, OVF=1; OVF remains 1 until CLEAR pulse, then 0.
// - STOP with prescaler=1 -> PAUSE. Wait 20 cycles: COUNT unchanged. START -> next increment occurs 2 cycles after resume.
// - In RUN at COUNT=0x07, LAP:
//   - DISP frozen at 0x07 while COUNT continues to 0x12.
//   - LAP again -> DISP=COUNT.
//   - STOP while in HOLD also releases DISP.
// - CLEAR, STOP and START asserted in the same cycle during RUN -> IDLE, COUNT=0x00. START is ignored.
// - RST asserted mid-cycle at COUNT=0x45 -> outputs zero immediately, before the next Clk edge; STATE=00.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// bcd_stopwatch_ctrl_pkg: shared FSM encodings and BCD constants for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// bcd_stopwatch_ctrl_if: command and display bundle between a stopwatch controller and its user
interface bcd_stopwatch_ctrl_if #(parameter int NUM_DIGITS = 4);
  logic                    START;
  logic                    STOP;
  logic                    CLEAR;
  logic                    LAP;
  logic [4*NUM_DIGITS-1:0] COUNT;
  logic [4*NUM_DIGITS-1:0] DISP;
  logic                    RUNNING;
  logic                    OVF;
  logic [1:0]              STATE;
  modport master (output START, STOP, CLEAR, LAP, input COUNT, DISP, RUNNING, OVF, STATE);
  modport slave  (input START, STOP, CLEAR, LAP, output COUNT, DISP, RUNNING, OVF, STATE);
endinterface

// File: rtl/bcd_stopwatch_ctrl_bcd_digit.sv
// bcd_digit: one mod-10 decade counter with terminal-count flag
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       Clk,
  input  logic       RST,
  input  logic       EN,
  input  logic       CLR,
  output logic [3:0] Q,
  output logic       TC
);
  assign TC = Q == BCD_MAX;
  // values above 9 are illegal and recover to 0 on the next enable
  always_ff @(posedge Clk or posedge RST)
    if (RST) Q <= '0;
    else if (CLR) Q <= '0;
    else if (EN) Q <= Q >= BCD_MAX ? 4'd0 : Q + 4'd1;
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl: start/stop/clear/lap sequencer driving a rippled chain of decade counters
module bcd_stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16
) (
  input logic Clk,
  input logic RST,
  bcd_stopwatch_ctrl_if.slave sw
);
  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(PRESCALE - 1);
  state_t state, state_nx;
  logic [PRESCALE_W-1:0] pre;
  logic [4*NUM_DIGITS-1:0] count, lap_q;
  logic [NUM_DIGITS-1:0] tc;
  logic [NUM_DIGITS:0] carry;
  logic active, tick, ovf;
  assign active = state == ST_RUN || state == ST_HOLD;
  assign tick   = active && pre == PRE_MAX && !sw.STOP && !sw.CLEAR;
  always_comb begin
    state_nx = state;
    if (sw.CLEAR) state_nx = ST_IDLE;
    else if (sw.STOP) state_nx = active ? ST_PAUSE : state;
    else if (sw.START) state_nx = active ? state : ST_RUN;
    else if (sw.LAP) state_nx = state == ST_RUN ? ST_HOLD : state == ST_HOLD ? ST_RUN : state;
  end
  // prescaler keeps its phase across PAUSE so a resume loses no fraction of a tick
  always_ff @(posedge Clk or posedge RST)
    if (RST) begin
      state <= ST_IDLE;
      pre   <= '0;
      lap_q <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      pre   <= sw.CLEAR ? '0 : !active ? pre : pre == PRE_MAX ? '0 : pre + 1'b1;
      lap_q <= sw.CLEAR ? '0 : (state == ST_RUN && state_nx == ST_HOLD) ? count : lap_q;
      ovf   <= !sw.CLEAR && (ovf || carry[NUM_DIGITS]);
    end
  assign carry[0] = tick;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    bcd_digit u_dig (
      .Clk (Clk),
      .RST (RST),
      .EN  (carry[d]),
      .CLR (sw.CLEAR),
      .Q   (count[4*d +: 4]),
      .TC  (tc[d])
    );
    assign carry[d+1] = carry[d] & tc[d];
  end
  assign sw.COUNT   = count;
  assign sw.DISP    = state == ST_HOLD ? lap_q : count;
  assign sw.RUNNING = active;
  assign sw.OVF     = ovf;
  assign sw.STATE   = state;
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb_bcd_stopwatch_ctrl: scenario tasks plus random commands checked against an integer stopwatch model
module tb_bcd_stopwatch_ctrl;
  logic Clk = 1'b0;
  logic RST;
  int total = 0;
  int bad = 0;
  int m_state, m_count, m_pre, m_lap;
  bit m_ovf;
  logic [19:0] got;
  bcd_stopwatch_ctrl_if #(.NUM_DIGITS(2)) sw ();
  bcd_stopwatch_ctrl #(.NUM_DIGITS(2), .PRESCALE(3), .PRESCALE_W(2)) dut (
    .Clk (Clk),
    .RST (RST),
    .sw  (sw.slave)
  );
  always #5 Clk = ~Clk;
  assign got = {sw.COUNT, sw.DISP, sw.STATE, sw.RUNNING, sw.OVF};

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [19:0] expv();
    bit run = m_state == 1 || m_state == 3;
    int disp = m_state == 3 ? m_lap : m_count;
    return {bcd(m_count), bcd(disp), 2'(m_state), run, m_ovf};
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_pre = 0; m_lap = 0; m_ovf = 0;
  endtask

  // one clock of stimulus; the model advances by the stopwatch rules, outputs settle #1 later
  task automatic step(input bit s = 0, input bit p = 0, input bit c = 0, input bit l = 0);
    bit act;
    bit tick;
    int ns;
    sw.START = s; sw.STOP = p; sw.CLEAR = c; sw.LAP = l;
    @(posedge Clk);
    act  = m_state == 1 || m_state == 3;
    tick = act && m_pre == 2 && !p && !c;
    if (c) model_reset();
    else begin
      ns = p ? (act ? 2 : m_state) : s ? (act ? m_state : 1) :
           l ? (m_state == 1 ? 3 : m_state == 3 ? 1 : m_state) : m_state;
      if (m_state == 1 && ns == 3) m_lap = m_count;
      if (act) m_pre = (m_pre + 1) % 3;
      if (tick) begin
        if (m_count == 99) begin m_count = 0; m_ovf = 1; end
        else m_count++;
      end
      m_state = ns;
    end
    #1;
    sw.START = 0; sw.STOP = 0; sw.CLEAR = 0; sw.LAP = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    sw.START = 0; sw.STOP = 0; sw.CLEAR = 0; sw.LAP = 0;
    model_reset();
    @(posedge Clk); #1;
    total++;
    if (got !== 20'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", got, 20'h0); end
    @(negedge Clk) RST = 1'b0;
  endtask

  task automatic test_start();
    step(1);
    total++;
    if (sw.STATE !== 2'b01) begin bad++; $display("FAIL start_state got=%b exp=01", sw.STATE); end
    for (int i = 1; i <= 30; i++) begin
      step();
      total++;
      if (got !== expv()) begin bad++; $display("FAIL start_run cyc=%0d got=%h exp=%h", i, got, expv()); end
      if (i == 3) begin
        total++;
        if (sw.COUNT !== 8'h01) begin bad++; $display("FAIL first_tick got=%h exp=01", sw.COUNT); end
      end
      if (i == 30) begin
        total++;
        if (sw.COUNT !== 8'h10) begin bad++; $display("FAIL tenth_tick got=%h exp=10", sw.COUNT); end
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 400 && !m_ovf; i++) begin
      step();
      total++;
      if (got !== expv()) begin bad++; $display("FAIL ovf_run cyc=%0d got=%h exp=%h", i, got, expv()); end
    end
    total++;
    if (!m_ovf || {sw.OVF, sw.COUNT} !== 9'h100) begin
      bad++; $display("FAIL rollover got ovf=%b count=%h exp ovf=1 count=00", sw.OVF, sw.COUNT);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (sw.OVF !== 1'b1) begin bad++; $display("FAIL ovf_sticky cyc=%0d got=%b exp=1", i, sw.OVF); end
    end
    step(0, 0, 1);
    total++;
    if ({sw.OVF, sw.STATE, sw.COUNT} !== 11'h0) begin
      bad++; $display("FAIL ovf_clear got ovf=%b state=%b count=%h exp 0/00/00", sw.OVF, sw.STATE, sw.COUNT);
    end
  endtask

  task automatic test_pause();
    int c0;
    logic [7:0] sv;
    step(1);
    for (int i = 0; i < 40 && !(m_count == 3 && m_pre == 1); i++) step();
    total++;
    if (!(m_count == 3 && m_pre == 1) || got !== expv()) begin
      bad++; $display("FAIL pause_setup got=%h exp=%h", got, expv());
    end
    c0 = m_count;
    sv = sw.COUNT;
    step(0, 1);
    total++;
    if (sw.STATE !== 2'b10) begin bad++; $display("FAIL pause_state got=%b exp=10", sw.STATE); end
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (sw.COUNT !== sv) begin bad++; $display("FAIL pause_hold cyc=%0d got=%h exp=%h", i, sw.COUNT, sv); end
    end
    step(1);
    total++;
    if (sw.COUNT !== sv || sw.STATE !== 2'b01) begin
      bad++; $display("FAIL resume got count=%h state=%b exp count=%h state=01", sw.COUNT, sw.STATE, sv);
    end
    step();
    total++;
    if (sw.COUNT !== bcd(c0 + 1)) begin bad++; $display("FAIL resume_tick got=%h exp=%h", sw.COUNT, bcd(c0 + 1)); end
  endtask

  task automatic test_lap();
    step(0, 0, 1);
    step(1);
    for (int i = 0; i < 40 && m_count != 7; i++) step();
    step(0, 0, 0, 1);
    total++;
    if (sw.STATE !== 2'b11 || sw.DISP !== 8'h07) begin
      bad++; $display("FAIL lap_capture got state=%b disp=%h exp state=11 disp=07", sw.STATE, sw.DISP);
    end
    for (int i = 0; i < 40 && m_count != 12; i++) begin
      step();
      total++;
      if (sw.DISP !== 8'h07 || got !== expv()) begin
        bad++; $display("FAIL lap_frozen cyc=%0d got=%h exp=%h", i, got, expv());
      end
    end
    total++;
    if (sw.COUNT !== 8'h12) begin bad++; $display("FAIL lap_count got=%h exp=12", sw.COUNT); end
    step(0, 0, 0, 1);
    total++;
    if (sw.DISP !== sw.COUNT || sw.STATE !== 2'b01 || got !== expv()) begin
      bad++; $display("FAIL lap_release got=%h exp=%h", got, expv());
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step();
    step(0, 1);
    total++;
    if (sw.DISP !== sw.COUNT || sw.STATE !== 2'b10 || got !== expv()) begin
      bad++; $display("FAIL hold_stop got=%h exp=%h", got, expv());
    end
  endtask

  task automatic test_priority();
    step(1);
    for (int i = 0; i < 5; i++) step();
    step(1, 1, 1, 0);
    total++;
    if ({sw.STATE, sw.COUNT} !== 10'h0 || got !== expv()) begin
      bad++; $display("FAIL clear_priority got=%h exp=%h", got, expv());
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1);
    step(1);
    for (int i = 0; i < 200 && m_count != 45; i++) step();
    total++;
    if (sw.COUNT !== 8'h45) begin bad++; $display("FAIL pre_reset_count got=%h exp=45", sw.COUNT); end
    #2 RST = 1'b1;
    #1;
    total++;
    if (got !== 20'h0) begin bad++; $display("FAIL async_reset got=%h exp=%h", got, 20'h0); end
    model_reset();
    @(negedge Clk) RST = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10);
      total++;
      if (got !== expv()) begin bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_overflow();
    test_pause();
    test_lap();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
